// File: rtl/pipelined_cla_adder_if.sv
// Operand/result bus for pipelined_cla_adder.
//   in_valid/in_ready   : operand beat handshake (producer -> adder)
//   a, b, cin, sub      : operands, carry-in, subtract select
//   out_valid/out_ready : result beat handshake (adder -> consumer)
//   sum, cout, overflow : result, carry out of MSB, signed overflow
// The master modport is the producer/consumer side and the slave modport
// is the adder.
interface pipelined_cla_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Each of the STAGES = WIDTH/GROUP pipeline stages resolves one GROUP-bit
// lookahead group and registers its carry out into the next stage.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (drops all in-flight beats)
//   bus : pipelined_cla_adder_if.slave
//         sub=0 -> sum = a + b + cin ; sub=1 -> sum = a - b (cin ignored)
//         cout = carry out of MSB (1 = no borrow when subtracting)
//         overflow = carry into MSB ^ carry out of MSB
// The whole pipe advances when the output slot is empty or being consumed,
// otherwise every stage (bubbles included) holds.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0) begin : g_width_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end

    typedef logic [WIDTH-1:0] word_t;

    // Operands are kept right-aligned: each stage consumes the low GROUP
    // bits and shifts the rest down. The sum is built from the top, so
    // after STAGES shifts it sits in its natural position.
    word_t a_q     [STAGES];
    word_t a_d     [STAGES];
    word_t b_q     [STAGES];
    word_t b_d     [STAGES];
    word_t sum_q   [STAGES];
    word_t sum_d   [STAGES];
    logic  valid_q [STAGES];
    logic  valid_d [STAGES];
    logic  carry_q [STAGES];
    logic  carry_d [STAGES];
    logic  cmsb_q;
    logic  cmsb_d;

    logic             adv;
    word_t            src_a;
    word_t            src_b;
    word_t            src_s;
    logic             src_c;
    logic             src_v;
    logic [GROUP-1:0] grp_g;
    logic [GROUP-1:0] grp_p;
    logic [GROUP:0]   grp_c;

    // Flat lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0.
    // Every carry is a sum of products over g/p/c0, never a prior carry.
    function automatic logic [GROUP:0] group_carries(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int unsigned i = 0; i < GROUP; i++) begin
            term = c0;
            for (int unsigned m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = term;
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    assign adv          = !valid_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        src_a  = '0;
        src_b  = '0;
        src_s  = '0;
        src_c  = 1'b0;
        src_v  = 1'b0;
        grp_g  = '0;
        grp_p  = '0;
        grp_c  = '0;
        cmsb_d = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_a = bus.a;
                src_b = bus.sub ? ~bus.b : bus.b;
                src_s = '0;
                src_c = bus.sub ? 1'b1 : bus.cin;
                src_v = bus.in_valid;
            end else begin
                src_a = a_q[k-1];
                src_b = b_q[k-1];
                src_s = sum_q[k-1];
                src_c = carry_q[k-1];
                src_v = valid_q[k-1];
            end
            grp_g      = src_a[GROUP-1:0] & src_b[GROUP-1:0];
            grp_p      = src_a[GROUP-1:0] ^ src_b[GROUP-1:0];
            grp_c      = group_carries(grp_g, grp_p, src_c);
            valid_d[k] = src_v;
            a_d[k]     = src_a >> GROUP;
            b_d[k]     = src_b >> GROUP;
            sum_d[k]   = (src_s >> GROUP)
                       | (word_t'(grp_p ^ grp_c[GROUP-1:0]) << (WIDTH - GROUP));
            carry_d[k] = grp_c[GROUP];
            if (k == STAGES - 1) cmsb_d = grp_c[GROUP-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
            end
            cmsb_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
            end
            cmsb_q <= cmsb_d;
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.cout      = carry_q[STAGES-1];
    assign bus.overflow  = cmsb_q ^ carry_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;
    localparam int unsigned W      = 16;
    localparam int unsigned STAGES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(W)) bus ();

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          nchk = 0;
    int          nerr = 0;
    int          cyc  = 0;
    logic [17:0] exp_q[$];
    int          iss_q[$];
    logic        check_lat  = 1'b0;
    logic        use_const  = 1'b0;
    logic [17:0] const_exp  = '0;
    logic        hold_v     = 1'b0;
    logic [17:0] held       = '0;
    logic        acc;
    logic        pending;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {cout, overflow, sum}; overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] t;
        logic        ovf;
        bb  = sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        ovf = (a[15] == bb[15]) && (t[15] != a[15]);
        return {t[16], ovf, t[15:0]};
    endfunction

    task automatic tick(output logic accepted);
        logic [17:0] e;
        logic [17:0] obs;
        int          t;
        accepted = 1'b0;
        @(negedge clk);
        if (!rst) begin
            obs = {bus.cout, bus.overflow, bus.sum};
            if (hold_v) check("stall_hold", {13'd0, bus.out_valid, obs}, {13'd0, 1'b1, held});
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    t = iss_q.pop_front();
                    check("result", {14'd0, obs}, {14'd0, e});
                    if (check_lat) check("latency", cyc - t, STAGES);
                end
            end
            if (bus.out_valid && !bus.out_ready) check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            hold_v = bus.out_valid && !bus.out_ready;
            held   = obs;
            if (bus.in_valid && bus.in_ready) begin
                accepted = 1'b1;
                exp_q.push_back(use_const ? const_exp : model(bus.a, bus.b, bus.cin, bus.sub));
                iss_q.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic cst, input logic [17:0] ce);
        logic got;
        got          = 1'b0;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        use_const    = cst;
        const_exp    = ce;
        for (int n = 0; n < 50 && !got; n++) tick(got);
        check("accepted", {31'd0, got}, 32'd1);
        bus.in_valid = 1'b0;
        use_const    = 1'b0;
    endtask

    task automatic drain();
        logic dummy;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick(dummy);
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", {14'd0, bus.cout, bus.overflow, bus.sum}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed arithmetic with hand-derived expectations
        check_lat = 1'b1;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000});
        drain();
        issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1, {1'b0, 1'b1, 16'h8000});
        drain();
        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        drain();
        issue(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        drain();

        // Streaming: 8 back-to-back beats
        for (int i = 0; i < 8; i++) issue(16'(i * 16'h1111), 16'h0F0F, 1'b0, 1'b0, 1'b0, '0);
        drain();

        // Bubbles: gapped input keeps fixed latency
        for (int i = 0; i < 4; i++) begin
            issue(16'(16'h1234 * (i + 1)), 16'hF00D, 1'(i), 1'(i >> 1), 1'b0, '0);
            tick(acc);
        end
        drain();

        // Backpressure: fill pipe, stall 3 cycles with a beat waiting
        check_lat     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(16'(16'h4000 + i), 16'(16'h3FFF - i), 1'b1, 1'b0, 1'b0, '0);
        bus.a        = 16'hABCD;
        bus.b        = 16'h1111;
        bus.cin      = 1'b0;
        bus.sub      = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            check("stall_no_accept", {31'd0, acc}, 32'd0);
        end
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) tick(acc);
        check("release_accept", {31'd0, acc}, 32'd1);
        drain();

        // Randomised valid/ready against the scoreboard
        pending = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!pending) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.a        = 16'($urandom);
                    bus.b        = 16'($urandom);
                    bus.cin      = 1'($urandom);
                    bus.sub      = 1'($urandom);
                    bus.in_valid = 1'b1;
                    pending      = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick(acc);
            if (acc) begin
                pending      = 1'b0;
                bus.in_valid = 1'b0;
            end
        end
        hold_v = 1'b0;
        drain();

        // Reset with 3 beats in flight
        check_lat = 1'b1;
        for (int i = 0; i < 3; i++) issue(16'(16'h0101 * (i + 1)), 16'h00FF, 1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        exp_q.delete();
        iss_q.delete();
        hold_v = 1'b0;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_result", {14'd0, bus.cout, bus.overflow, bus.sum}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick(acc);
            check("midrst_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 16'h5556});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
